// File: rtl/regfile_bus_arbiter.sv
// Two-requester arbiter and access sequencer for the shared-bus 32x32 file register.
// Round-robin grant in IDLE, one access at a time, bus turnaround after every write.
module regfile_bus_arbiter #(
    parameter int ZERO_PROTECT = 1,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              rw0,
    input  logic [4:0]        addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    input  logic              req1,
    input  logic              rw1,
    input  logic [4:0]        addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              rf_we,
    output logic [4:0]        rf_write_addr,
    output logic [4:0]        rf_read0_addr,
    output logic [4:0]        rf_read1_addr,
    output logic              rf_bus_oe,
    output logic [DATA_W-1:0] rf_bus_out,
    input  logic [DATA_W-1:0] rf_bus_in
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        TURN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              rr_last_q, rr_last_d;
    logic              own_q, own_d;
    logic [4:0]        addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_cap_q, rd_cap_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rf_we_q, rf_we_d;
    logic              rf_bus_oe_q, rf_bus_oe_d;
    logic [4:0]        rf_write_addr_q, rf_write_addr_d;
    logic [4:0]        rf_read_addr_q, rf_read_addr_d;
    logic [DATA_W-1:0] rf_bus_out_q, rf_bus_out_d;
    logic              pick1;
    logic              wr_en;

    // A state names what the output registers load on the edge leaving it,
    // so bus activity for a state becomes visible one cycle later.
    always_comb begin
        state_d         = state_q;
        rr_last_d       = rr_last_q;
        own_d           = own_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rd_cap_d        = 1'b0;
        gnt0_d          = 1'b0;
        gnt1_d          = 1'b0;
        done0_d         = 1'b0;
        done1_d         = 1'b0;
        rdata_d         = rdata_q;
        rf_we_d         = 1'b0;
        rf_bus_oe_d     = 1'b0;
        rf_write_addr_d = rf_write_addr_q;
        rf_read_addr_d  = rf_read_addr_q;
        rf_bus_out_d    = rf_bus_out_q;
        pick1           = req1 && (!req0 || !rr_last_q);
        wr_en           = !((ZERO_PROTECT != 0) && (addr_q == 5'd0));

        // Read address is on the bus this cycle; capture and complete.
        if (rd_cap_q) begin
            rdata_d = rf_bus_in;
            done0_d = !own_q;
            done1_d = own_q;
        end

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    own_d     = pick1;
                    rr_last_d = pick1;
                    gnt0_d    = !pick1;
                    gnt1_d    = pick1;
                    addr_d    = pick1 ? addr1 : addr0;
                    wdata_d   = pick1 ? wdata1 : wdata0;
                    state_d   = (pick1 ? rw1 : rw0) ? WRITE : READ;
                end
            end
            WRITE: begin
                rf_we_d         = wr_en;
                rf_bus_oe_d     = wr_en;
                rf_write_addr_d = addr_q;
                rf_bus_out_d    = wdata_q;
                state_d         = TURN;
            end
            TURN: begin
                done0_d = !own_q;
                done1_d = own_q;
                state_d = IDLE;
            end
            READ: begin
                rf_read_addr_d = addr_q;
                rd_cap_d       = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            rr_last_q       <= 1'b1;
            own_q           <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rd_cap_q        <= 1'b0;
            gnt0_q          <= 1'b0;
            gnt1_q          <= 1'b0;
            done0_q         <= 1'b0;
            done1_q         <= 1'b0;
            rdata_q         <= '0;
            rf_we_q         <= 1'b0;
            rf_bus_oe_q     <= 1'b0;
            rf_write_addr_q <= '0;
            rf_read_addr_q  <= '0;
            rf_bus_out_q    <= '0;
        end else begin
            state_q         <= state_d;
            rr_last_q       <= rr_last_d;
            own_q           <= own_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            rd_cap_q        <= rd_cap_d;
            gnt0_q          <= gnt0_d;
            gnt1_q          <= gnt1_d;
            done0_q         <= done0_d;
            done1_q         <= done1_d;
            rdata_q         <= rdata_d;
            rf_we_q         <= rf_we_d;
            rf_bus_oe_q     <= rf_bus_oe_d;
            rf_write_addr_q <= rf_write_addr_d;
            rf_read_addr_q  <= rf_read_addr_d;
            rf_bus_out_q    <= rf_bus_out_d;
        end
    end

    assign gnt0          = gnt0_q;
    assign gnt1          = gnt1_q;
    assign done0         = done0_q;
    assign done1         = done1_q;
    assign rdata         = rdata_q;
    assign rf_we         = rf_we_q;
    assign rf_bus_oe     = rf_bus_oe_q;
    assign rf_write_addr = rf_write_addr_q;
    assign rf_read0_addr = rf_read_addr_q;
    assign rf_read1_addr = rf_read_addr_q;
    assign rf_bus_out    = rf_bus_out_q;

endmodule

// File: tb/tb_regfile_bus_arbiter.sv
// Bench for regfile_bus_arbiter: directed scenarios plus random traffic, checked each
// cycle against a transaction schedule built from the grant/latency rules.
module tb_regfile_bus_arbiter;

    localparam int DATA_W = 32;
    localparam int ZP     = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0 = 1'b0, rw0 = 1'b0, req1 = 1'b0, rw1 = 1'b0;
    logic [4:0]        addr0 = '0, addr1 = '0;
    logic [31:0]       wdata0 = '0, wdata1 = '0;
    logic              gnt0, gnt1, done0, done1;
    logic [31:0]       rdata;
    logic              rf_we, rf_bus_oe;
    logic [4:0]        rf_write_addr, rf_read0_addr, rf_read1_addr;
    logic [31:0]       rf_bus_out, rf_bus_in;

    regfile_bus_arbiter #(.ZERO_PROTECT(ZP), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
        .rdata(rdata), .rf_we(rf_we), .rf_write_addr(rf_write_addr),
        .rf_read0_addr(rf_read0_addr), .rf_read1_addr(rf_read1_addr),
        .rf_bus_oe(rf_bus_oe), .rf_bus_out(rf_bus_out), .rf_bus_in(rf_bus_in)
    );

    always #5 clk = ~clk;

    // File register and resolved shared bus.
    logic [31:0] rfm [32];
    assign rf_bus_in = rf_bus_oe ? rf_bus_out : rfm[rf_read1_addr];
    always @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < 32; j++) rfm[j] <= '0;
        end else if (rf_we) begin
            rfm[rf_write_addr] <= rf_bus_in;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Expected-event schedule, indexed by cycle number modulo 16.
    logic        eg0 [16], eg1 [16], ed0 [16], ed1 [16], ewe [16], erv [16], erd [16];
    logic [4:0]  ewa [16], era [16];
    logic [31:0] ewd [16], erdval [16];
    logic [31:0] refmem [32];
    int          cyc = 0;
    int          free_at = 0;
    int          k, w;
    logic        rr_last = 1'b1;
    logic        m_rw, m_wen;
    logic [4:0]  m_a;
    logic [31:0] m_d;
    logic [3:0]  t0, t1, t2;

    task automatic clear_slot(input logic [3:0] s);
        eg0[s] = 1'b0; eg1[s] = 1'b0; ed0[s] = 1'b0; ed1[s] = 1'b0;
        ewe[s] = 1'b0; erv[s] = 1'b0; erd[s] = 1'b0;
        ewa[s] = '0; era[s] = '0; ewd[s] = '0; erdval[s] = '0;
    endtask

    // Reference model: on each edge decide whether a grant happens, then schedule
    // the grant (next cycle), bus phase (+1) and completion (+2).
    initial begin
        forever begin
            @(posedge clk);
            k   = cyc;
            cyc = cyc + 1;
            t0  = 4'(cyc);
            t1  = t0 + 4'd1;
            t2  = t0 + 4'd2;
            if (!rst) begin
                for (int j = 0; j < 16; j++) clear_slot(4'(j));
                for (int j = 0; j < 32; j++) refmem[j] = '0;
                free_at = 0;
                rr_last = 1'b1;
            end else begin
                clear_slot(t2);
                if (k >= free_at && (req0 || req1)) begin
                    if (req0 && req1) w = (rr_last == 1'b0) ? 1 : 0;
                    else              w = req0 ? 0 : 1;
                    m_rw    = (w == 1) ? rw1 : rw0;
                    m_a     = (w == 1) ? addr1 : addr0;
                    m_d     = (w == 1) ? wdata1 : wdata0;
                    rr_last = (w == 1);
                    if (w == 0) begin eg0[t0] = 1'b1; ed0[t2] = 1'b1; end
                    else        begin eg1[t0] = 1'b1; ed1[t2] = 1'b1; end
                    if (m_rw) begin
                        m_wen   = !(ZP != 0 && m_a == 5'd0);
                        ewe[t1] = m_wen;
                        ewa[t1] = m_a;
                        ewd[t1] = m_d;
                        if (m_wen) refmem[m_a] = m_d;
                        free_at = cyc + 2;
                    end else begin
                        erv[t1]    = 1'b1;
                        era[t1]    = m_a;
                        erd[t2]    = 1'b1;
                        erdval[t2] = refmem[m_a];
                        free_at    = cyc + 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the schedule.
    logic [31:0] exp_rdata = '0;
    logic [3:0]  ci;
    logic        on;
    initial begin
        forever begin
            @(negedge clk);
            ci = 4'(cyc);
            on = rst;
            if (!on) exp_rdata = '0;
            else if (erd[ci]) exp_rdata = erdval[ci];
            chk("gnt0", 32'(gnt0), 32'(on && eg0[ci]));
            chk("gnt1", 32'(gnt1), 32'(on && eg1[ci]));
            chk("done0", 32'(done0), 32'(on && ed0[ci]));
            chk("done1", 32'(done1), 32'(on && ed1[ci]));
            chk("rf_we", 32'(rf_we), 32'(on && ewe[ci]));
            chk("rf_bus_oe", 32'(rf_bus_oe), 32'(on && ewe[ci]));
            chk("rdata", rdata, exp_rdata);
            chk("read_addr_pair", 32'(rf_read0_addr), 32'(rf_read1_addr));
            if (on && ewe[ci]) begin
                chk("write_addr", 32'(rf_write_addr), 32'(ewa[ci]));
                chk("bus_out", rf_bus_out, ewd[ci]);
            end
            if (on && erv[ci]) chk("read_addr", 32'(rf_read1_addr), 32'(era[ci]));
            if (!on) begin
                chk("rst_write_addr", 32'(rf_write_addr), 32'd0);
                chk("rst_read_addr", 32'(rf_read0_addr), 32'd0);
                chk("rst_bus_out", rf_bus_out, 32'd0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int x, input logic rw, input logic [4:0] a, input logic [31:0] d);
        if (x == 0) begin req0 = 1'b1; rw0 = rw; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; rw1 = rw; addr1 = a; wdata1 = d; end
    endtask

    task automatic drop(input int x);
        if (x == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    // Request, hold until granted (bounded), then release; returns in the grant cycle.
    task automatic one_shot(input int x, input logic rw, input logic [4:0] a, input logic [31:0] d);
        logic got;
        got = 1'b0;
        set_req(x, rw, a, d);
        for (int n = 0; n < 10 && !got; n++) begin
            tick();
            got = (x == 0) ? gnt0 : gnt1;
        end
        drop(x);
        chk("grant_wait", 32'(got), 32'd1);
    endtask

    task automatic rand_phase(input int ncyc);
        logic [1:0] pend;
        logic       g;
        pend = 2'b00;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            for (int x = 0; x < 2; x++) begin
                g = (x == 0) ? gnt0 : gnt1;
                if (g || (pend[x[0]] && $urandom_range(15) == 0)) begin
                    drop(x);
                    pend[x[0]] = 1'b0;
                end
                if (!pend[x[0]] && $urandom_range(3) == 0) begin
                    set_req(x, 1'($urandom_range(1)), 5'($urandom_range(7)), $urandom);
                    pend[x[0]] = 1'b1;
                end
            end
        end
        drop(0);
        drop(1);
    endtask

    initial begin
        logic [31:0] v;
        int          ng0, ng1;
        logic        got;

        #2 rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;

        // Both requesters hold reads: grants alternate 0,1,0,... every 2 cycles.
        set_req(0, 1'b0, 5'd3, '0);
        set_req(1, 1'b0, 5'd4, '0);
        ng0 = 0;
        ng1 = 0;
        repeat (12) begin
            tick();
            ng0 += int'(gnt0);
            ng1 += int'(gnt1);
        end
        drop(0);
        drop(1);
        chk("alt_gnt0_count", 32'(ng0), 32'd3);
        chk("alt_gnt1_count", 32'(ng1), 32'd3);
        repeat (3) tick();

        // Write then read of address 5.
        one_shot(0, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        chk("wr5_we", 32'(rf_we), 32'd1);
        chk("wr5_oe", 32'(rf_bus_oe), 32'd1);
        tick();
        chk("wr5_done", 32'(done0), 32'd1);
        chk("wr5_oe_off", 32'(rf_bus_oe), 32'd0);
        one_shot(0, 1'b0, 5'd5, '0);
        tick();
        tick();
        chk("rd5_done", 32'(done0), 32'd1);
        chk("rd5_data", rdata, 32'hDEADBEEF);
        repeat (2) tick();

        // Write of 7 immediately followed by a read of 7.
        v = $urandom;
        one_shot(1, 1'b1, 5'd7, v);
        one_shot(1, 1'b0, 5'd7, '0);
        tick();
        tick();
        chk("rd7_done", 32'(done1), 32'd1);
        chk("rd7_data", rdata, v);
        repeat (2) tick();

        // Protected write to address 0.
        one_shot(0, 1'b1, 5'd0, 32'h12345678);
        tick();
        chk("zp_we", 32'(rf_we), 32'd0);
        tick();
        chk("zp_done", 32'(done0), 32'd1);
        chk("zp_we_end", 32'(rf_we), 32'd0);
        one_shot(0, 1'b0, 5'd0, '0);
        tick();
        tick();
        chk("zp_read", rdata, 32'd0);
        repeat (2) tick();

        rand_phase(400);
        repeat (4) tick();

        // Reset in the middle of a write.
        one_shot(0, 1'b1, 5'd9, $urandom);
        @(posedge clk);
        #2;
        chk("mid_we_active", 32'(rf_we), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_we", 32'(rf_we), 32'd0);
        chk("async_rst_oe", 32'(rf_bus_oe), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        set_req(0, 1'b0, 5'd1, '0);
        set_req(1, 1'b0, 5'd2, '0);
        got = 1'b0;
        for (int n = 0; n < 6 && !got; n++) begin
            tick();
            got = gnt0 || gnt1;
        end
        drop(0);
        drop(1);
        chk("tie_grant_seen", 32'(got), 32'd1);
        chk("tie_gnt0_after_rst", 32'(gnt0), 32'd1);
        chk("tie_gnt1_after_rst", 32'(gnt1), 32'd0);
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
